// File: rtl/latency_unit_arbiter_if.sv
// Handshake bundle between requesters, the shared unit and the
// response consumer of latency_unit_arbiter.
interface latency_unit_arbiter_if #(
   parameter int NREQ  = 2,
   parameter int WIDTH = 8
);
   localparam int IDW = $clog2(NREQ);

   logic [NREQ-1:0]       req_valid;
   logic [NREQ*WIDTH-1:0] req_data;
   logic [NREQ-1:0]       req_ready;
   logic [WIDTH-1:0]      unit_in;
   logic [WIDTH-1:0]      unit_out;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [WIDTH-1:0]      rsp_data;
   logic [IDW-1:0]        rsp_id;
   logic                  busy;

   modport master (
      output req_valid, req_data, unit_out, rsp_ready,
      input  req_ready, unit_in, rsp_valid, rsp_data, rsp_id, busy
   );

   modport slave (
      input  req_valid, req_data, unit_out, rsp_ready,
      output req_ready, unit_in, rsp_valid, rsp_data, rsp_id, busy
   );
endinterface

// File: rtl/latency_unit_arbiter.sv
// Round-robin scheduler for a non-stallable fixed-latency unit with
// a tag pipeline, in-order response FIFO and credit-based issue.
module latency_unit_arbiter #(
   parameter int NREQ       = 2,
   parameter int WIDTH      = 8,
   parameter int LATENCY    = 5,
   parameter int FIFO_DEPTH = 8
) (
   input  logic clk,
   input  logic rst,
   latency_unit_arbiter_if.slave bus
);
   localparam int IDW = $clog2(NREQ);
   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam logic [AW:0]    DEPTH_C = (AW+1)'(FIFO_DEPTH);
   localparam logic [IDW-1:0] LAST_C  = IDW'(NREQ-1);

   logic [AW:0]          r_occ;
   logic [IDW-1:0]       r_last;
   logic [LATENCY-1:0]   r_tv;
   logic [IDW-1:0]       r_tid [LATENCY];
   logic [WIDTH-1:0]     r_mem [FIFO_DEPTH];
   logic [IDW-1:0]       r_mid [FIFO_DEPTH];
   logic [AW-1:0]        r_wp;
   logic [AW-1:0]        r_rp;
   logic [AW:0]          r_cnt;

   logic                 w_can_issue;
   logic                 w_any;
   logic [IDW-1:0]       w_gid;
   logic [NREQ-1:0]      w_grant;
   logic                 w_push;
   logic                 w_pop;
   logic                 w_rsp_valid;

   assign w_can_issue = !rst && (r_occ < DEPTH_C);
   assign w_push      = r_tv[LATENCY-1];
   assign w_rsp_valid = (r_cnt != '0);
   assign w_pop       = w_rsp_valid && bus.rsp_ready;

   // Round-robin search upward from the requester after the last winner.
   always_comb begin
      int v_sum;
      logic [IDW-1:0] v_idx;
      v_sum   = 0;
      v_idx   = '0;
      w_any   = 1'b0;
      w_gid   = '0;
      w_grant = '0;
      if (w_can_issue) begin
         for (int k = 1; k <= NREQ; k++) begin
            v_sum = int'(r_last) + k;
            v_idx = IDW'(v_sum % NREQ);
            if (!w_any && bus.req_valid[v_idx]) begin
               w_any = 1'b1;
               w_gid = v_idx;
            end
         end
      end
      if (w_any) w_grant[w_gid] = 1'b1;
   end

   assign bus.req_ready = w_grant;
   assign bus.unit_in   = w_any ? bus.req_data[int'(w_gid)*WIDTH +: WIDTH]
                                : '0;

   // Remember the winner so the next search starts just past it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)        r_last <= LAST_C;
      else if (w_any) r_last <= w_gid;
   end

   // Credits: requests in the unit plus entries parked in the FIFO.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_occ <= '0;
      end else begin
         unique case ({w_any, w_pop})
            2'b10:   r_occ <= r_occ + 1'b1;
            2'b01:   r_occ <= r_occ - 1'b1;
            default: r_occ <= r_occ;
         endcase
      end
   end

   // Tag pipeline tracks which requester owns each unit stage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tv <= '0;
         for (int i = 0; i < LATENCY; i++) r_tid[i] <= '0;
      end else begin
         r_tv[0]  <= w_any;
         r_tid[0] <= w_gid;
         for (int i = 1; i < LATENCY; i++) begin
            r_tv[i]  <= r_tv[i-1];
            r_tid[i] <= r_tid[i-1];
         end
      end
   end

   // FIFO storage; contents are masked at the output while empty.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wp] <= bus.unit_out;
         r_mid[r_wp] <= r_tid[LATENCY-1];
      end
   end

   // FIFO pointers and count; credits make a full-FIFO push impossible.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_push) begin
            assert (r_cnt != DEPTH_C) else $error("response fifo overflow");
            r_wp <= r_wp + 1'b1;
         end
         if (w_pop) r_rp <= r_rp + 1'b1;
         unique case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   assign bus.rsp_valid = w_rsp_valid;
   assign bus.rsp_data  = w_rsp_valid ? r_mem[r_rp] : '0;
   assign bus.rsp_id    = w_rsp_valid ? r_mid[r_rp] : '0;
   assign bus.busy      = (r_occ != '0);
endmodule
